// File: rtl/hbus_pkg.sv
// Shared definitions for the HyperBus delay-line calibration sequencer:
// FSM state encoding and the counter-width helper.
package hbus_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETTLE = 3'd1;
  localparam state_t ST_CHECK  = 3'd2;
  localparam state_t ST_NEXT   = 3'd3;
  localparam state_t ST_RESULT = 3'd4;

  // One counter serves both the settle countdown (SETTLE_CYCLES-1 .. 0) and
  // the verdict count (0 .. CHECK_LEN-1), so it must hold max-1 of the two.
  function automatic int cnt_width(input int settle_cycles, input int check_len);
    int mx;
    mx = (settle_cycles > check_len) ? settle_cycles : check_len;
    return (mx <= 2) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/hbus_dly_cal_if.sv
// Handshake/status bundle between the calibration sequencer and its
// surroundings (comparator, delay line, host).
interface hbus_dly_cal_if #(
  parameter int N = 3
);

  logic                  start;
  logic                  chk_valid;
  logic                  chk_ok;
  logic [N-1:0]          delay;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic [N:0]            win_len;
  logic [(1 << N)-1:0]   pass_map;

  modport master (
    output start, chk_valid, chk_ok,
    input  delay, busy, done, found, win_len, pass_map
  );

  modport slave (
    input  start, chk_valid, chk_ok,
    output delay, busy, done, found, win_len, pass_map
  );

endinterface

// File: rtl/hbus_dly_cal_win.sv
// Run/best-window tracker: follows the current run of passing taps and keeps
// the first longest run seen since the last clear. Runs never wrap.
module hbus_dly_cal_win
  import hbus_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         strobe,
  input  logic         verdict,
  input  logic [N-1:0] tap,
  output logic [N-1:0] best_start,
  output logic [N:0]   best_len
);

  logic [N-1:0] cur_start_r;
  logic [N:0]   cur_len_r;
  logic [N-1:0] best_start_r;
  logic [N:0]   best_len_r;
  logic [N-1:0] run_start_s;
  logic [N:0]   run_len_s;

  // Run state as it will be after folding in this tap's verdict.
  always_comb begin
    run_start_s = cur_start_r;
    run_len_s   = cur_len_r;
    if (verdict) begin
      run_len_s = cur_len_r + (N+1)'(1);
      if (cur_len_r == (N+1)'(0)) begin
        run_start_s = tap;
      end else begin
        run_start_s = cur_start_r;
      end
    end else begin
      run_len_s   = (N+1)'(0);
      run_start_s = cur_start_r;
    end
  end

  // Commit the run and promote it on a strictly longer length (first run wins ties).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cur_start_r  <= N'(0);
      cur_len_r    <= (N+1)'(0);
      best_start_r <= N'(0);
      best_len_r   <= (N+1)'(0);
    end else if (strobe) begin
      cur_start_r <= run_start_s;
      cur_len_r   <= run_len_s;
      if (run_len_s > best_len_r) begin
        best_start_r <= run_start_s;
        best_len_r   <= run_len_s;
      end
    end
  end

  assign best_start = best_start_r;
  assign best_len   = best_len_r;

endmodule

// File: rtl/hbus_dly_cal.sv
// HyperBus delay-line calibration sequencer. Sweeps every tap, collects
// comparator verdicts per tap, then parks the delay line on the centre of
// the longest contiguous passing window.
// Optional per-tap pass bitmap on pass_map: define HBUS_DLY_CAL_MAP_EN.
module hbus_dly_cal
  import hbus_pkg::*;
#(
  parameter int N             = 3,
  parameter int SETTLE_CYCLES = 16,
  parameter int CHECK_LEN     = 8
) (
  input  logic          clk,
  input  logic          rst,
  hbus_dly_cal_if.slave bus
);

  localparam int           CW          = cnt_width(SETTLE_CYCLES, CHECK_LEN);
  localparam logic [N-1:0] TAP_LAST    = N'((1 << N) - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CHK_LAST    = CW'(CHECK_LEN - 1);

  // The delay line needs 2^N+1 idle cycles to flush after a tap change.
  if (SETTLE_CYCLES < (1 << N) + 1) begin : g_bad_settle
    $error("hbus_dly_cal: SETTLE_CYCLES must be >= 2^N+1");
  end
  if (CHECK_LEN < 1) begin : g_bad_check
    $error("hbus_dly_cal: CHECK_LEN must be >= 1");
  end

  state_t        state_r, state_s;
  logic [N-1:0]  tap_r, tap_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          verdict_r, verdict_s;
  logic [N-1:0]  delay_r, delay_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          found_r, found_s;
  logic [N:0]    win_len_r, win_len_s;
  logic          win_clear_s;
  logic          win_strobe_s;
  logic [N-1:0]  best_start_s;
  logic [N:0]    best_len_s;

  hbus_dly_cal_win #(.N(N)) u_win (
    .clk       (clk),
    .rst       (rst),
    .clear     (win_clear_s),
    .strobe    (win_strobe_s),
    .verdict   (verdict_r),
    .tap       (tap_r),
    .best_start(best_start_s),
    .best_len  (best_len_s)
  );

  // State and datapath registers; reset aborts any sweep without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      tap_r     <= N'(0);
      cnt_r     <= CW'(0);
      verdict_r <= 1'b0;
      delay_r   <= N'(0);
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      found_r   <= 1'b0;
      win_len_r <= (N+1)'(0);
    end else begin
      state_r   <= state_s;
      tap_r     <= tap_s;
      cnt_r     <= cnt_s;
      verdict_r <= verdict_s;
      delay_r   <= delay_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      found_r   <= found_s;
      win_len_r <= win_len_s;
    end
  end

  // Next-state decode of the sweep sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_s = ST_SETTLE;
        else           state_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cnt_r == CW'(0)) state_s = ST_CHECK;
        else                 state_s = ST_SETTLE;
      end
      ST_CHECK: begin
        if (bus.chk_valid && (!bus.chk_ok || cnt_r == CHK_LAST)) state_s = ST_NEXT;
        else                                                     state_s = ST_CHECK;
      end
      ST_NEXT: begin
        if (tap_r == TAP_LAST) state_s = ST_RESULT;
        else                   state_s = ST_SETTLE;
      end
      ST_RESULT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, tap/counter and tracker controls.
  always_comb begin
    tap_s        = tap_r;
    cnt_s        = cnt_r;
    verdict_s    = verdict_r;
    delay_s      = delay_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    found_s      = found_r;
    win_len_s    = win_len_r;
    win_clear_s  = 1'b0;
    win_strobe_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          tap_s       = N'(0);
          delay_s     = N'(0);
          busy_s      = 1'b1;
          cnt_s       = SETTLE_LAST;
          win_clear_s = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == CW'(0)) cnt_s = CW'(0);
        else                 cnt_s = cnt_r - CW'(1);
      end
      ST_CHECK: begin
        if (bus.chk_valid) begin
          if (!bus.chk_ok) begin
            verdict_s = 1'b0;
          end else if (cnt_r == CHK_LAST) begin
            verdict_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_NEXT: begin
        win_strobe_s = 1'b1;
        if (tap_r == TAP_LAST) begin
          tap_s = tap_r;
        end else begin
          tap_s   = tap_r + N'(1);
          delay_s = tap_r + N'(1);
          cnt_s   = SETTLE_LAST;
        end
      end
      ST_RESULT: begin
        if (best_len_s != (N+1)'(0)) begin
          // Floor centre; best_start + (best_len-1)/2 always fits in N bits.
          delay_s = best_start_s + N'((best_len_s - (N+1)'(1)) >> 1);
          found_s = 1'b1;
        end else begin
          delay_s = N'(0);
          found_s = 1'b0;
        end
        win_len_s = best_len_s;
        done_s    = 1'b1;
        busy_s    = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

`ifdef HBUS_DLY_CAL_MAP_EN
  logic [(1 << N)-1:0] map_r;

  // Per-tap verdict bitmap, cleared at sweep start and held after it.
  always_ff @(posedge clk) begin
    if (rst || win_clear_s) begin
      map_r <= {(1 << N){1'b0}};
    end else if (win_strobe_s) begin
      map_r[tap_r] <= verdict_r;
    end
  end

  assign bus.pass_map = map_r;
`else
  assign bus.pass_map = {(1 << N){1'b0}};
`endif

  assign bus.delay   = delay_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.found   = found_r;
  assign bus.win_len = win_len_r;

endmodule

// File: tb/tb_hbus_dly_cal.sv
// Directed testbench for hbus_dly_cal (N=3, SETTLE_CYCLES=16, CHECK_LEN=8).
// Comparator model: verdict ok = mask[delay], valid every gap-th cycle
// counted from the last tap change. Expected done cycles are hand computed.
module tb_hbus_dly_cal;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

`ifdef HBUS_DLY_CAL_MAP_EN
  localparam bit MAP_ON = 1'b1;
`else
  localparam bit MAP_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  hbus_dly_cal_if #(.N(3)) bus_if ();

  hbus_dly_cal #(.N(3), .SETTLE_CYCLES(16), .CHECK_LEN(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_map(input logic [7:0] m);
    return MAP_ON ? m : 8'h00;
  endfunction

  // One sweep: pulse start, play the comparator, then check the result.
  // rst_at >= 0 asserts rst at that cycle and checks the abort instead.
  task automatic sweep(input string name, input logic [7:0] mask, input int gap,
                       input bit poke, input int exp_cyc, input logic [2:0] exp_delay,
                       input logic exp_found, input logic [3:0] exp_len, input int rst_at);
    int         ph;
    int         first_done;
    int         n_done;
    int         seq_err;
    int         exp_tap;
    logic [2:0] prev;
    logic [2:0] d_dly;
    logic       d_found;
    logic       d_busy;
    logic [3:0] d_len;
    logic [7:0] d_map;
    ph = 0; first_done = -1; n_done = 0; seq_err = 0; exp_tap = 0; prev = 3'd0;
    d_dly = 3'd0; d_found = 1'b0; d_busy = 1'b1; d_len = 4'd0; d_map = 8'h00;
    @(negedge clk);
    bus_if.start = 1'b1;
    for (int k = 0; k <= exp_cyc + 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check({name, " busy@start"}, {31'd0, bus_if.busy}, 32'd1);
        check({name, " delay@start"}, {29'd0, bus_if.delay}, 32'd0);
        ph = 0;
      end else if (bus_if.busy && bus_if.delay != prev) begin
        exp_tap++;
        if (int'(bus_if.delay) != exp_tap) seq_err++;
        ph = 0;
      end else begin
        ph++;
      end
      prev = bus_if.delay;
      if (bus_if.done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = k;
          d_dly = bus_if.delay; d_found = bus_if.found; d_busy = bus_if.busy;
          d_len = bus_if.win_len; d_map = bus_if.pass_map;
        end
      end
      bus_if.start     = (poke && (k == 60 || k == 120)) ? 1'b1 : 1'b0;
      bus_if.chk_valid = ((ph % gap) == (gap - 1));
      bus_if.chk_ok    = mask[bus_if.delay];
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check({name, " rst delay"}, {29'd0, bus_if.delay}, 32'd0);
        check({name, " rst busy"}, {31'd0, bus_if.busy}, 32'd0);
        check({name, " rst found"}, {31'd0, bus_if.found}, 32'd0);
        check({name, " rst win_len"}, {28'd0, bus_if.win_len}, 32'd0);
        rst = 1'b0;
        bus_if.chk_valid = 1'b0;
        for (int j = 0; j < 250; j++) begin
          @(negedge clk);
          if (bus_if.done || bus_if.busy) n_done++;
        end
        check({name, " no done/busy after rst"}, n_done, 32'd0);
        return;
      end
    end
    bus_if.chk_valid = 1'b0;
    bus_if.chk_ok    = 1'b0;
    check({name, " done cycle"}, first_done, exp_cyc);
    check({name, " done count"}, n_done, 32'd1);
    check({name, " tap sequence"}, seq_err, 32'd0);
    check({name, " last tap"}, exp_tap, 32'd7);
    check({name, " delay"}, {29'd0, d_dly}, {29'd0, exp_delay});
    check({name, " found"}, {31'd0, d_found}, {31'd0, exp_found});
    check({name, " busy@done"}, {31'd0, d_busy}, 32'd0);
    check({name, " win_len"}, {28'd0, d_len}, {28'd0, exp_len});
    check({name, " pass_map"}, {24'd0, d_map}, {24'd0, exp_map(mask)});
  endtask

  initial begin
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.chk_valid = 1'b0;
    bus_if.chk_ok = 1'b0;
    repeat (3) @(negedge clk);
    check("reset delay", {29'd0, bus_if.delay}, 32'd0);
    check("reset busy", {31'd0, bus_if.busy}, 32'd0);
    check("reset done", {31'd0, bus_if.done}, 32'd0);
    check("reset found", {31'd0, bus_if.found}, 32'd0);
    check("reset win_len", {28'd0, bus_if.win_len}, 32'd0);
    check("reset pass_map", {24'd0, bus_if.pass_map}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // name           mask   gap poke done  delay found len  rst_at
    sweep("all_pass", 8'hFF, 1, 1'b0, 201, 3'd3, 1'b1, 4'd8, -1);
    sweep("mid_win",  8'h3C, 1, 1'b0, 173, 3'd3, 1'b1, 4'd4, -1);
    sweep("tie_runs", 8'h63, 1, 1'b0, 173, 3'd0, 1'b1, 4'd2, -1);
    sweep("all_fail", 8'h00, 1, 1'b0, 145, 3'd0, 1'b0, 4'd0, -1);
    sweep("last_tap", 8'h80, 1, 1'b0, 152, 3'd7, 1'b1, 4'd1, -1);
    sweep("gapped",   8'h3C, 3, 1'b1, 237, 3'd3, 1'b1, 4'd4, -1);
    sweep("rst_mid",  8'hFF, 1, 1'b0, 201, 3'd0, 1'b0, 4'd0, 118);
    sweep("after_rst", 8'hFF, 1, 1'b0, 201, 3'd3, 1'b1, 4'd8, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
